// File: rtl/seq_comparator_pkg.sv
// Shared types and helpers for the sequential chunked magnitude comparator.
// State encoding, chunk-count math and cascade result normalisation.
package seq_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Result triple is {lt, eq, gt}; a malformed cascade degrades to "equal".
    function automatic logic [2:0] cascade_result(input logic [2:0] c);
        if (c == 3'b100 || c == 3'b010 || c == 3'b001) begin
            return c;
        end
        return 3'b010;
    endfunction

endpackage

// File: rtl/seq_comparator_chunk_compare.sv
// Combinational unsigned compare of one CHUNK-bit slice.
// Zero latency; invert_msb flips both sign bits so a signed top chunk orders correctly.
module chunk_compare #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             invert_msb,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    logic [CHUNK-1:0] a_m;
    logic [CHUNK-1:0] b_m;

    always_comb begin
        a_m = a;
        b_m = b;
        if (invert_msb) begin
            a_m[CHUNK-1] = ~a[CHUNK-1];
            b_m[CHUNK-1] = ~b[CHUNK-1];
        end
        lt = (a_m < b_m);
        eq = (a_m == b_m);
        gt = (a_m > b_m);
    end

endmodule

// File: rtl/seq_comparator.sv
// Sequential WIDTH-bit comparator walking CHUNK-bit slices MSB first with early exit.
// Latency = chunks examined (1..NUM_CHUNKS); one request at a time, result held until out_ready.
module seq_comparator
    import seq_comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK),
    localparam int CU_W       = $clog2(NUM_CHUNKS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             lt_in,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [CU_W-1:0]  chunks_used
);

    localparam int EXT_W = NUM_CHUNKS * CHUNK;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [EXT_W-1:0] LO_MASK = EXT_W'({WIDTH{1'b1}});
    localparam logic [EXT_W-1:0] HI_MASK = ~LO_MASK;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [CU_W-1:0]  NC_CU   = CU_W'(NUM_CHUNKS);

    state_t             state_q, state_d;
    logic [EXT_W-1:0]   a_q, a_d;
    logic [EXT_W-1:0]   b_q, b_d;
    logic               signed_q, signed_d;
    logic [2:0]         casc_q, casc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [2:0]         res_q, res_d;
    logic [CU_W-1:0]    chunks_used_q, chunks_used_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic               c_lt, c_eq, c_gt;
    logic               invert_msb;

    assign a_chunk    = CHUNK'(a_q >> (idx_q * CHUNK));
    assign b_chunk    = CHUNK'(b_q >> (idx_q * CHUNK));
    assign invert_msb = signed_q && (idx_q == TOP_IDX);

    chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
        .a          (a_chunk),
        .b          (b_chunk),
        .invert_msb (invert_msb),
        .lt         (c_lt),
        .eq         (c_eq),
        .gt         (c_gt)
    );

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        signed_d      = signed_q;
        casc_d        = casc_q;
        idx_d         = idx_q;
        res_d         = res_q;
        chunks_used_d = chunks_used_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Extend to a whole number of chunks so the top chunk carries the sign.
                    a_d      = EXT_W'(a) | ((signed_mode && a[WIDTH-1]) ? HI_MASK : '0);
                    b_d      = EXT_W'(b) | ((signed_mode && b[WIDTH-1]) ? HI_MASK : '0);
                    signed_d = signed_mode;
                    casc_d   = {lt_in, eq_in, gt_in};
                    idx_d    = TOP_IDX;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (!c_eq) begin
                    res_d         = {c_lt, 1'b0, c_gt};
                    chunks_used_d = NC_CU - CU_W'(idx_q);
                    state_d       = DONE;
                end else if (idx_q == '0) begin
                    res_d         = cascade_result(casc_q);
                    chunks_used_d = NC_CU;
                    state_d       = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            signed_q      <= 1'b0;
            casc_q        <= '0;
            idx_q         <= '0;
            res_q         <= '0;
            chunks_used_q <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            signed_q      <= signed_d;
            casc_q        <= casc_d;
            idx_q         <= idx_d;
            res_q         <= res_d;
            chunks_used_q <= chunks_used_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign lt          = res_q[2];
    assign eq          = res_q[1];
    assign gt          = res_q[0];
    assign chunks_used = chunks_used_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator (WIDTH=32, CHUNK=4): directed vectors push
// expected {lt,eq,gt}, chunk count and accept cycle; a monitor pops on each result.
module tb_seq_comparator;

    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_mode;
    logic        lt_in, eq_in, gt_in;
    logic        out_valid;
    logic        out_ready;
    logic        lt, eq, gt;
    logic [3:0]  chunks_used;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [2:0] res;
        int         m;
        int         acc;
    } exp_t;

    exp_t sb[$];

    seq_comparator #(.WIDTH(32), .CHUNK(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .lt_in       (lt_in),
        .eq_in       (eq_in),
        .gt_in       (gt_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .lt          (lt),
        .eq          (eq),
        .gt          (gt),
        .chunks_used (chunks_used)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Drives a request and waits (bounded) for the accepting edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ism,
                         input logic [2:0] casc, input logic [2:0] eres, input int em,
                         input bit push, input bit drop, output int acc);
        a           = ia;
        b           = ib;
        signed_mode = ism;
        {lt_in, eq_in, gt_in} = casc;
        in_valid    = 1'b1;
        acc         = -1;
        for (int n = 0; n < 60; n++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) fail_now("accept_timeout");
        else if (push) sb.push_back('{eres, em, acc});
        if (drop) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("idle_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},    {31'd0, in_ready},    32'd1);
        check({tag, "_out_valid"},   {31'd0, out_valid},   32'd0);
        check({tag, "_lt_eq_gt"},    {29'd0, lt, eq, gt},  32'd0);
        check({tag, "_chunks_used"}, {28'd0, chunks_used}, 32'd0);
    endtask

    // Monitor: pops on each rising out_valid, checks stability while held.
    initial begin : monitor
        exp_t       e;
        logic       prev;
        logic [2:0] held_res;
        logic [3:0] held_cu;
        prev     = 1'b0;
        held_res = '0;
        held_cu  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                check("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
                if (!prev) begin
                    if (sb.size() == 0) begin
                        fail_now("spurious_out_valid");
                    end else begin
                        e = sb.pop_front();
                        check("result_lt_eq_gt", {29'd0, lt, eq, gt}, {29'd0, e.res});
                        check("chunks_used", {28'd0, chunks_used}, e.m);
                        check("latency", cyc - e.acc, e.m);
                    end
                    held_res = {lt, eq, gt};
                    held_cu  = chunks_used;
                end else begin
                    check("held_result", {29'd0, lt, eq, gt}, {29'd0, held_res});
                    check("held_chunks_used", {28'd0, chunks_used}, {28'd0, held_cu});
                end
            end
            prev = rst_n && out_valid;
        end
    end

    initial begin : stimulus
        int acc, acc2, rel;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        {lt_in, eq_in, gt_in} = 3'b000;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;

        // First accept on the first rising edge after reset release.
        issue(32'h8000_0000, 32'h0000_0000, 1'b0, 3'b000, R_GT, 1, 1, 1, acc);
        check("accept_after_reset", acc - rel, 1);
        issue(32'h8000_0000, 32'h0000_0000, 1'b1, 3'b000, R_LT, 1, 1, 1, acc);
        issue(32'h1234_5678, 32'h1234_5678, 1'b0, 3'b100, R_LT, 8, 1, 1, acc);
        issue(32'hFFFF_FFF0, 32'hFFFF_FFF1, 1'b1, 3'b000, R_LT, 8, 1, 1, acc);
        issue(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 3'b101, R_EQ, 8, 1, 1, acc);
        issue(32'h0000_0000, 32'h0000_0000, 1'b1, 3'b001, R_GT, 8, 1, 1, acc);

        // Held in_valid: operands change mid-flight, second accept waits for the handshake.
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 3'b000, R_LT, 8, 1, 0, acc);
        issue(32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 3'b000, R_LT, 1, 1, 1, acc2);
        check("back_to_back_accept_gap", acc2 - acc, 10);

        // Backpressure: out_ready low for 5 DONE cycles.
        wait_idle();
        out_ready = 1'b0;
        issue(32'h0000_0050, 32'h0000_0030, 1'b0, 3'b000, R_GT, 7, 1, 1, acc);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail_now("out_valid_timeout");
        end
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_handshake_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_after_handshake_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the 3rd BUSY cycle discards the transaction.
        wait_idle();
        issue(32'h0000_0000, 32'h0000_0000, 1'b0, 3'b010, R_EQ, 8, 0, 1, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        issue(32'h0000_0300, 32'h0000_0400, 1'b0, 3'b000, R_LT, 6, 1, 1, acc);
        check("accept_after_midreset", acc - rel, 1);

        wait_idle();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
